product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of the 4x4 array multiplier. Sums N_TERMS consecutive 8-bit
//   products into a 16-bit accumulator using a valid/ready input handshake.
//   Streams the finished sum out as two bytes over an 8-bit valid/ready port.
//   Turns the combinational product into a multiply-accumulate (dot-product) result.
// PARAMETERS
//   N_TERMS       4   products summed per result; legal range 1..256 (sum can never exceed 16 bits)
//   OUT_HI_FIRST  0   0: low byte sent first; 1: high byte sent first
// PORTS
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   ena         in   1   1 = advance; 0 = freeze all state, prod_ready forced 0
//   clear       in   1   synchronous abort/clear of the current batch
//   prod_in     in   8   product from multiplier (p[7:0])
//   prod_valid  in   1   prod_in is valid this cycle
//   prod_ready  out  1   block can accept a product this cycle
//   out_data    out  8   result byte
//   out_valid   out  1   out_data is valid
//   out_last    out  1   asserted with the second (final) byte of a result
//   out_ready   in   1   consumer accepts out_data this cycle
//   busy        out  1   batch in progress (term count != 0) or result being sent
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=ACCUM, acc=16'h0000, cnt=0.
//     Outputs on reset: prod_ready=1 (if ena), out_valid=0, out_last=0, out_data=8'h00, busy=0.
//   States: ACCUM, SEND_0 (first byte), SEND_1 (second byte).
//   ACCUM:
//     - prod_ready = ena.
//     - Accept when prod_valid & prod_ready.
//     - If cnt < N_TERMS-1: acc <= acc + {8'h00, prod_in}; cnt <= cnt+1.
//     - If cnt == N_TERMS-1: acc <= acc + prod_in; cnt <= 0; next state SEND_0.
//     - Latency: last term accepted at edge t -> out_valid=1 from cycle t+1.
//   SEND_0:
//     - out_valid=1; out_data = acc[7:0] (acc[15:8] if OUT_HI_FIRST); out_last=0.
//     - prod_ready=0.
//     - On out_valid & out_ready & ena -> SEND_1.
//   SEND_1:
//     - out_valid=1; out_data = other byte; out_last=1; prod_ready=0.
//     - On handshake -> ACCUM with acc <= 0.
//   Outputs when not sending: out_data=8'h00, out_valid=0, out_last=0.
//   Output stability: out_data/out_valid are registered-state-driven and must not change
//     while out_valid=1 & out_ready=0 (hold until accepted).
//   Arithmetic: zero-extend prod_in to 16 bits; plain unsigned add; no overflow possible
//     for N_TERMS<=256 (max 256*255=65280), so no flag.
//   N_TERMS=1: each accepted product goes straight to SEND_0; result = {8'h00, prod_in}.
//   prod_valid while prod_ready=0: ignored; upstream must hold data (no drop, no count).
//   clear=1 (ena=1): highest priority. acc<=0, cnt<=0, state<=ACCUM in the same edge.
//     Any partial batch or unsent result is discarded; a product offered that cycle is NOT accepted.
//   ena=0: no state change at all (clear also ignored); out_valid keeps its current value.
//   Reset mid-batch or mid-send: immediate return to reset values, no partial output.
//   busy = (state != ACCUM) | (cnt != 0).
// TESTING
//   1. N_TERMS=4, four products 8'hE1 (15*15) back to back, out_ready=1
//      -> out 8'h84 (last=0) then 8'h03 (last=1); sum 900.
//   2. Same stimulus with out_ready=0 for 5 cycles after out_valid
//      -> 8'h84 held stable, prod_ready=0 throughout; then normal 2-byte drain.
//   3. Products 1,2,3 then clear=1 with prod_valid=1 (value 9), then 4 products of 1
//      -> result 16'h0004; the 9 is not accepted.
//   4. N_TERMS=256, 256 products of 8'hFF
//      -> bytes 8'h00, 8'hFF (16'hFF00), last on the second byte.
//   5. rst_n pulsed low asynchronously mid-SEND_1
//      -> out_valid=0 and busy=0 immediately; the next 4 products yield a fresh correct sum.
//   6. ena=0 for 3 cycles mid-batch with prod_valid=1
//      -> prod_ready=0, cnt/acc unchanged; batch completes correctly after ena=1.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Byte-stream bus for the product accumulator: product input handshake
// on one side, result byte output handshake on the other.
interface product_accumulator_if;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic       prod_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output prod_in,
        output prod_valid,
        output out_ready,
        input  prod_ready,
        input  out_data,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  prod_in,
        input  prod_valid,
        input  out_ready,
        output prod_ready,
        output out_data,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums N_TERMS consecutive 8-bit products
// into a 16-bit accumulator, then streams the result out as two bytes.
// The sum cannot overflow 16 bits for N_TERMS <= 256 (256*255 = 65280).
module product_accumulator #(
    parameter int N_TERMS      = 4,
    parameter bit OUT_HI_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  clear,
    product_accumulator_if.slave  bus,
    output logic                  busy
);

    // A single-term batch still needs a one-bit counter that never leaves 0.
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        ACCUM,
        SEND_0,
        SEND_1
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [15:0]      acc_next;

    assign acc_next       = acc + {8'h00, bus.prod_in};
    assign bus.prod_ready = ena & (state == ACCUM);
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign busy           = (state != ACCUM) | (cnt != '0);

    // Batch/send FSM; output byte, valid and last are registered alongside the state
    // so they stay put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= 16'h0000;
            cnt         <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                state       <= ACCUM;
                acc         <= 16'h0000;
                cnt         <= '0;
                out_data_q  <= 8'h00;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (bus.prod_valid) begin
                            acc <= acc_next;
                            if (cnt == LAST_CNT) begin
                                cnt         <= '0;
                                state       <= SEND_0;
                                out_valid_q <= 1'b1;
                                out_last_q  <= 1'b0;
                                out_data_q  <= OUT_HI_FIRST ? acc_next[15:8] : acc_next[7:0];
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    SEND_0: begin
                        if (bus.out_ready) begin
                            state      <= SEND_1;
                            out_last_q <= 1'b1;
                            out_data_q <= OUT_HI_FIRST ? acc[7:0] : acc[15:8];
                        end
                    end
                    SEND_1: begin
                        if (bus.out_ready) begin
                            state       <= ACCUM;
                            acc         <= 16'h0000;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= 8'h00;
                        end
                    end
                    default: begin
                        state <= ACCUM;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three configurations share one stimulus
// stream and are each compared every cycle against a batch/queue model.
module tb_product_accumulator;

    localparam int NT [3] = '{4, 256, 1};
    localparam bit HF [3] = '{1'b0, 1'b0, 1'b1};

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clear;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic       out_ready;

    logic [2:0]      dut_ready;
    logic [2:0]      dut_valid;
    logic [2:0]      dut_last;
    logic [2:0]      dut_busy;
    logic [2:0][7:0] dut_data;

    int vectors;
    int miscompares;

    int          m_sum  [3];
    int          m_cnt  [3];
    int          m_pend [3];
    logic [15:0] m_res  [3];

    logic [7:0]  cap_first [3];
    logic [15:0] cap_word  [3];

    product_accumulator_if bus0 ();
    product_accumulator_if bus1 ();
    product_accumulator_if bus2 ();

    assign bus0.prod_in = prod_in;
    assign bus0.prod_valid = prod_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.prod_in = prod_in;
    assign bus1.prod_valid = prod_valid;
    assign bus1.out_ready = out_ready;
    assign bus2.prod_in = prod_in;
    assign bus2.prod_valid = prod_valid;
    assign bus2.out_ready = out_ready;

    assign dut_ready = {bus2.prod_ready, bus1.prod_ready, bus0.prod_ready};
    assign dut_valid = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign dut_last  = {bus2.out_last, bus1.out_last, bus0.out_last};
    assign dut_data  = {bus2.out_data, bus1.out_data, bus0.out_data};

    product_accumulator #(.N_TERMS(4), .OUT_HI_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus0), .busy(dut_busy[0])
    );
    product_accumulator #(.N_TERMS(256), .OUT_HI_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus1), .busy(dut_busy[1])
    );
    product_accumulator #(.N_TERMS(1), .OUT_HI_FIRST(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus2), .busy(dut_busy[2])
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            m_sum[i]  = 0;
            m_cnt[i]  = 0;
            m_pend[i] = 0;
            m_res[i]  = 16'h0000;
        end
    endtask

    // Model: a running batch sum plus a count of result bytes still to be sent.
    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_sum[i]  = 0;
                m_cnt[i]  = 0;
                m_pend[i] = 0;
            end else if (ena) begin
                if (clear) begin
                    m_sum[i]  = 0;
                    m_cnt[i]  = 0;
                    m_pend[i] = 0;
                end else if (m_pend[i] != 0) begin
                    if (out_ready) m_pend[i] = m_pend[i] - 1;
                end else if (prod_valid) begin
                    m_sum[i] = m_sum[i] + int'(prod_in);
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == NT[i]) begin
                        m_res[i]  = m_sum[i][15:0];
                        m_pend[i] = 2;
                        m_sum[i]  = 0;
                        m_cnt[i]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            logic [7:0]  first_b;
            logic [7:0]  second_b;
            logic [7:0]  exp_data;
            logic [11:0] exp_v;
            logic [11:0] act_v;
            first_b  = HF[i] ? m_res[i][15:8] : m_res[i][7:0];
            second_b = HF[i] ? m_res[i][7:0]  : m_res[i][15:8];
            exp_data = (m_pend[i] == 2) ? first_b : ((m_pend[i] == 1) ? second_b : 8'h00);
            exp_v = {ena & (m_pend[i] == 0), m_pend[i] != 0, m_pend[i] == 1,
                     (m_pend[i] != 0) || (m_cnt[i] != 0), exp_data};
            act_v = {dut_ready[i], dut_valid[i], dut_last[i], dut_busy[i], dut_data[i]};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL outputs inst%0d t=%0t: got rdy=%b vld=%b last=%b busy=%b data=%h, want rdy=%b vld=%b last=%b busy=%b data=%h",
                         i, $time, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                         exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
            if (rst_n && ena && !clear && out_ready && dut_valid[i]) begin
                if (dut_last[i])
                    cap_word[i] = HF[i] ? {cap_first[i], dut_data[i]} : {dut_data[i], cap_first[i]};
                else
                    cap_first[i] = dut_data[i];
            end
        end
    endtask

    task automatic checkLiteral(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic r,
                                 input logic e, input logic c);
        prod_valid = v;
        prod_in    = p;
        out_ready  = r;
        ena        = e;
        clear      = c;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic clearAll();
        for (int i = 0; i < 3; i++) cap_word[i] = 16'h0000;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        clear       = 1'b0;
        prod_in     = 8'h00;
        prod_valid  = 1'b0;
        out_ready   = 1'b1;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            cap_first[i] = 8'h00;
            cap_word[i]  = 16'h0000;
        end
        modelReset();

        #2;
        checkOutput();
        checkLiteral("reset_ready", {13'd0, dut_ready}, 16'h0007);
        checkLiteral("reset_valid_busy", {10'd0, dut_valid, dut_busy}, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Four 15*15 products -> 900 = 16'h0384.
        clearAll();
        repeat (4) applyStimulus(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkLiteral("t1_sum900", cap_word[0], 16'h0384);
        checkLiteral("t1_n1_hi_first", cap_word[2], 16'h00E1);

        // Consumer stalls on the first byte for five cycles.
        clearAll();
        repeat (4) applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            checkLiteral("t2_hold_data", {8'h00, dut_data[0]}, 16'h0084);
            checkLiteral("t2_hold_flags", {13'd0, dut_ready[0], dut_valid[0], dut_last[0]}, 16'h0002);
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkLiteral("t2_sum900", cap_word[0], 16'h0384);

        // Clear with a product offered discards the batch and the product.
        clearAll();
        applyStimulus(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b1, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkLiteral("t3_clear_sum", cap_word[0], 16'h0004);

        // Freeze mid-batch: 10+20 then 3 frozen cycles, then 30+40 -> 100.
        clearAll();
        applyStimulus(1'b1, 8'd10, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd20, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
            checkLiteral("t6_frozen", {14'd0, dut_ready[0], dut_busy[0]}, 16'h0001);
        end
        applyStimulus(1'b1, 8'd30, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd40, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkLiteral("t6_sum100", cap_word[0], 16'd100);

        // Asynchronous reset while the second byte is pending.
        clearAll();
        repeat (4) applyStimulus(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkLiteral("t5_in_send1", {14'd0, dut_valid[0], dut_last[0]}, 16'h0003);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkLiteral("t5_reset_now", {14'd0, dut_valid[0], dut_busy[0]}, 16'h0000);
        checkOutput();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) applyStimulus(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkLiteral("t5_fresh_sum", cap_word[0], 16'd28);

        // 256 full-scale products on the 256-term instance -> 16'hFF00.
        clearAll();
        repeat (256) applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkLiteral("t4_n256_sum", cap_word[1], 16'hFF00);

        // Random traffic with stalls, freezes and occasional clears.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 49) == 0);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
